// File: rtl/ddr_rdisplay_slave_mc.sv
// ddr_rdisplay_slave_mc
// ---------------------
// Display-path DDR read master. Refills the display FIFO with fixed-length
// burst reads and walks one frame per display vsync. The bank and camera
// channel are sampled only when a frame starts, so a frame is always fetched
// from a single buffer. A burst is finished by counting returned beats, not
// by grant edges. A vsync that arrives before the frame has been fetched
// completely is reported as an underrun.
//
// Ports
//   ddr_clk, ddr_rstn          clock, asynchronous active-low reset
//   rd_burst_data_valid/_data  read beats from DDR
//   w_fifo_clk/_en/_data       FIFO write side, beats forwarded unregistered
//   slave_req/_valid           burst request to the arbiter / command accepted
//   slave_raddr, rd_len        burst start address, burst length (constant)
//   fifo_level, fifo_full      FIFO write-side fill status
//   fifo_clearn                one-cycle active-low FIFO clear at frame start
//   sel_rd_load/_bank          strobe and bank number from the writer
//   read_channel               camera channel to display
//   vga_vs                     display vsync (asynchronous to ddr_clk)
//   frame_wr_done              pulse once the first full frame is in DDR
//   frame_active               high while a frame is being fetched
//   underrun_pulse/_cnt        underrun strobe and saturating count
//   frame_cnt                  wrapping count of frame starts
module ddr_rdisplay_slave_mc #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 25,
  parameter int OFF_W       = 18,
  parameter int CH_W        = 4,
  parameter int BANK_W      = 2,
  parameter int BURST_LEN   = 256,
  parameter int LEN_W       = 10,
  parameter int FRAME_WORDS = 245760,
  parameter int LVL_W       = 9,
  parameter int FIFO_THRESH = 250
) (
  input  logic              ddr_clk,
  input  logic              ddr_rstn,
  input  logic              rd_burst_data_valid,
  input  logic [DATA_W-1:0] rd_burst_data,
  output logic              w_fifo_clk,
  output logic              w_fifo_en,
  output logic [DATA_W-1:0] w_fifo_data,
  output logic              slave_req,
  input  logic              slave_valid,
  output logic [ADDR_W-1:0] slave_raddr,
  output logic [LEN_W-1:0]  rd_len,
  input  logic [LVL_W-1:0]  fifo_level,
  input  logic              fifo_full,
  output logic              fifo_clearn,
  input  logic              sel_rd_load,
  input  logic [BANK_W-1:0] sel_rd_bank,
  input  logic [CH_W-1:0]   read_channel,
  input  logic              vga_vs,
  input  logic              frame_wr_done,
  output logic              frame_active,
  output logic              underrun_pulse,
  output logic [15:0]       underrun_cnt,
  output logic [15:0]       frame_cnt
);

  localparam logic [LEN_W-1:0] BEAT_LAST  = LEN_W'(BURST_LEN - 1);
  localparam logic [OFF_W-1:0] OFF_STEP   = OFF_W'(BURST_LEN);
  localparam logic [OFF_W-1:0] OFF_END    = OFF_W'(FRAME_WORDS);
  localparam logic [LVL_W-1:0] THRESH_LVL = LVL_W'(FIFO_THRESH);

  typedef enum logic [2:0] {
    S_WAIT_WR, S_WAIT_VS, S_FILL, S_REQ, S_BURST, S_DONE
  } state_t;

  state_t              state_q;
  logic                vs_s0_q, vs_s1_q, vs_d1_q;
  logic                vs_pend_q;
  logic                wr_done_q;
  logic [BANK_W-1:0]   bank_q;
  logic [LEN_W-1:0]    beat_cnt_q;
  logic [ADDR_W-1:0]   slave_raddr_q;
  logic                slave_req_q;
  logic                fifo_clearn_q;
  logic                frame_active_q;
  logic                underrun_pulse_q;
  logic [15:0]         underrun_cnt_q;
  logic [15:0]         frame_cnt_q;

  logic                vs_fall;
  logic                vs_evt;
  logic                start_frame;
  logic [OFF_W-1:0]    offset_next;
  logic [ADDR_W-1:0]   frame_addr;

  // Beats go straight to the FIFO in every state, including during reset.
  assign w_fifo_clk  = ddr_clk;
  assign w_fifo_en   = rd_burst_data_valid;
  assign w_fifo_data = rd_burst_data;
  assign rd_len      = LEN_W'(BURST_LEN);

  assign slave_req      = slave_req_q;
  assign slave_raddr    = slave_raddr_q;
  assign fifo_clearn    = fifo_clearn_q;
  assign frame_active   = frame_active_q;
  assign underrun_pulse = underrun_pulse_q;
  assign underrun_cnt   = underrun_cnt_q;
  assign frame_cnt      = frame_cnt_q;

  // Two synchroniser flops plus one history flop for falling-edge detection.
  // Reset to 0 so that no false falling edge can appear right after reset.
  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      vs_s0_q <= 1'b0;
      vs_s1_q <= 1'b0;
      vs_d1_q <= 1'b0;
    end else begin
      vs_s0_q <= vga_vs;
      vs_s1_q <= vs_s0_q;
      vs_d1_q <= vs_s1_q;
    end
  end

  assign vs_fall = vs_d1_q & ~vs_s1_q;
  // A fresh edge is acted on in the same cycle it is detected, so the
  // frame-start clear lands three clocks after the pin edge.
  assign vs_evt  = vs_pend_q | vs_fall;

  // REQ and BURST never service a vsync: an issued command is always completed.
  assign start_frame = vs_evt &&
                       (state_q == S_WAIT_VS || state_q == S_DONE || state_q == S_FILL);

  assign offset_next = slave_raddr_q[OFF_W-1:0] + OFF_STEP;
  assign frame_addr  = (ADDR_W'(bank_q) << (ADDR_W - BANK_W)) |
                       (ADDR_W'(read_channel) << OFF_W);

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state_q          <= S_WAIT_WR;
      vs_pend_q        <= 1'b0;
      wr_done_q        <= 1'b0;
      bank_q           <= '0;
      beat_cnt_q       <= '0;
      slave_raddr_q    <= '0;
      slave_req_q      <= 1'b0;
      fifo_clearn_q    <= 1'b1;
      frame_active_q   <= 1'b0;
      underrun_pulse_q <= 1'b0;
      underrun_cnt_q   <= '0;
      frame_cnt_q      <= '0;
    end else begin
      fifo_clearn_q    <= 1'b1;
      underrun_pulse_q <= 1'b0;

      if (sel_rd_load)   bank_q    <= sel_rd_bank;
      if (frame_wr_done) wr_done_q <= 1'b1;
      if (vs_fall)       vs_pend_q <= 1'b1;

      case (state_q)
        S_WAIT_WR: begin
          if (wr_done_q) begin
            state_q   <= S_WAIT_VS;
            vs_pend_q <= 1'b0;
          end
        end
        S_FILL: begin
          if (!vs_evt && !fifo_full && (fifo_level < THRESH_LVL)) begin
            slave_req_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_REQ: begin
          if (slave_valid) begin
            slave_req_q <= 1'b0;
            beat_cnt_q  <= '0;
            state_q     <= S_BURST;
          end
        end
        S_BURST: begin
          if (rd_burst_data_valid) begin
            if (beat_cnt_q == BEAT_LAST) begin
              slave_raddr_q[OFF_W-1:0] <= offset_next;
              if (offset_next == OFF_END) begin
                frame_active_q <= 1'b0;
                state_q        <= S_DONE;
              end else begin
                state_q <= S_FILL;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        S_WAIT_VS, S_DONE: ;
        default: state_q <= S_WAIT_WR;
      endcase

      // A vsync seen while still filling means the previous frame was cut short.
      if (start_frame) begin
        slave_raddr_q  <= frame_addr;
        fifo_clearn_q  <= 1'b0;
        frame_active_q <= 1'b1;
        frame_cnt_q    <= frame_cnt_q + 16'd1;
        vs_pend_q      <= 1'b0;
        state_q        <= S_FILL;
        if (state_q == S_FILL) begin
          underrun_pulse_q <= 1'b1;
          if (underrun_cnt_q != 16'hFFFF) underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr_rdisplay_slave_mc.sv
module tb_ddr_rdisplay_slave_mc;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 25;
  localparam int BURST  = 256;
  localparam int FRAME  = 1024;

  logic              ddr_clk = 1'b0;
  logic              ddr_rstn;
  logic              rd_burst_data_valid;
  logic [DATA_W-1:0] rd_burst_data;
  logic              w_fifo_clk;
  logic              w_fifo_en;
  logic [DATA_W-1:0] w_fifo_data;
  logic              slave_req;
  logic              slave_valid;
  logic [ADDR_W-1:0] slave_raddr;
  logic [9:0]        rd_len;
  logic [8:0]        fifo_level;
  logic              fifo_full;
  logic              fifo_clearn;
  logic              sel_rd_load;
  logic [1:0]        sel_rd_bank;
  logic [3:0]        read_channel;
  logic              vga_vs;
  logic              frame_wr_done;
  logic              frame_active;
  logic              underrun_pulse;
  logic [15:0]       underrun_cnt;
  logic [15:0]       frame_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what the display path should look like, in plain numbers.
  int unsigned bank_m = 0;
  int unsigned frame_cnt_m = 0;
  int unsigned ur_m = 0;
  int unsigned base_m = 0;

  always #5 ddr_clk = ~ddr_clk;

  ddr_rdisplay_slave_mc #(
    .FRAME_WORDS(FRAME),
    .BURST_LEN  (BURST)
  ) dut (
    .ddr_clk            (ddr_clk),
    .ddr_rstn           (ddr_rstn),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .w_fifo_clk         (w_fifo_clk),
    .w_fifo_en          (w_fifo_en),
    .w_fifo_data        (w_fifo_data),
    .slave_req          (slave_req),
    .slave_valid        (slave_valid),
    .slave_raddr        (slave_raddr),
    .rd_len             (rd_len),
    .fifo_level         (fifo_level),
    .fifo_full          (fifo_full),
    .fifo_clearn        (fifo_clearn),
    .sel_rd_load        (sel_rd_load),
    .sel_rd_bank        (sel_rd_bank),
    .read_channel       (read_channel),
    .vga_vs             (vga_vs),
    .frame_wr_done      (frame_wr_done),
    .frame_active       (frame_active),
    .underrun_pulse     (underrun_pulse),
    .underrun_cnt       (underrun_cnt),
    .frame_cnt          (frame_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ddr_clk);
    #1;
  endtask

  function automatic int unsigned frame_base(input int unsigned bank, input int unsigned ch);
    return bank * 32'h0080_0000 + ch * 32'h0004_0000;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= 32'hFFFF) ? 32'hFFFF : v + 1;
  endfunction

  // Drive one vsync falling edge on the pin and check the frame-start reaction
  // three clocks later; exp_start says whether a frame should start at all.
  task automatic vsync_fall(input bit exp_start, input bit exp_ur);
    vga_vs = 1'b0;
    tick();
    tick();
    check("clearn_before", fifo_clearn, 1);
    tick();
    if (exp_start) begin
      frame_cnt_m = (frame_cnt_m + 1) % 65536;
      if (exp_ur) ur_m = sat_inc(ur_m);
      base_m = frame_base(bank_m, read_channel);
      check("fstart_raddr", slave_raddr, base_m);
      check("fstart_active", frame_active, 1);
    end
    check("clearn_at_start", fifo_clearn, exp_start ? 0 : 1);
    check("underrun_pulse", underrun_pulse, exp_ur);
    check("frame_cnt", frame_cnt, frame_cnt_m);
    check("underrun_cnt", underrun_cnt, ur_m);
    tick();
    check("clearn_after", fifo_clearn, 1);
    check("underrun_pulse_end", underrun_pulse, 0);
    vga_vs = 1'b1;
    repeat (3) tick();
  endtask

  // Wait (bounded) for a request, check its address, grant after gdel cycles,
  // then return BURST beats with random gaps. inject_vs drops vsync mid-burst.
  task automatic do_burst(input int unsigned exp_addr, input int gdel, input bit inject_vs);
    int n;
    logic [DATA_W-1:0] d;
    n = 0;
    while (slave_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("req_seen", slave_req, 1);
    check("burst_raddr", slave_raddr, exp_addr);
    check("rd_len", rd_len, BURST);
    for (int g = 0; g < gdel; g++) begin
      tick();
      check("req_hold", slave_req, 1);
      check("raddr_hold", slave_raddr, exp_addr);
    end
    slave_valid = 1'b1;
    tick();
    slave_valid = 1'b0;
    check("req_drop", slave_req, 0);
    for (int b = 0; b < BURST; b++) begin
      if ($urandom_range(3) == 0) tick();
      if (inject_vs && b == 64)  vga_vs = 1'b0;
      if (inject_vs && b == 160) vga_vs = 1'b1;
      d = $urandom;
      rd_burst_data_valid = 1'b1;
      rd_burst_data = d;
      #1;
      check("fifo_en", w_fifo_en, 1);
      check("fifo_data", w_fifo_data, d);
      tick();
      rd_burst_data_valid = 1'b0;
    end
  endtask

  task automatic finish_frame(input int first_k);
    for (int k = first_k; k < FRAME / BURST; k++) begin
      do_burst(base_m + k * BURST, $urandom_range(6), 1'b0);
      check("active_after_burst", frame_active, (k == FRAME / BURST - 1) ? 0 : 1);
    end
  endtask

  initial begin
    logic [ADDR_W-1:0] exp_addr_const;
    logic [DATA_W-1:0] d;
    int n;

    ddr_rstn = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data = '0;
    slave_valid = 1'b0;
    fifo_level = '0;
    fifo_full = 1'b0;
    sel_rd_load = 1'b0;
    sel_rd_bank = '0;
    read_channel = '0;
    vga_vs = 1'b1;
    frame_wr_done = 1'b0;

    repeat (3) tick();
    check("rst_req", slave_req, 0);
    check("rst_raddr", slave_raddr, 0);
    check("rst_clearn", fifo_clearn, 1);
    check("rst_active", frame_active, 0);
    check("rst_upulse", underrun_pulse, 0);
    check("rst_ucnt", underrun_cnt, 0);
    check("rst_fcnt", frame_cnt, 0);
    ddr_rstn = 1'b1;
    repeat (2) tick();

    // vsync before the writer has finished a frame: nothing happens
    vsync_fall(1'b0, 1'b0);
    vsync_fall(1'b0, 1'b0);
    check("no_req_before_wr", slave_req, 0);

    frame_wr_done = 1'b1;
    tick();
    frame_wr_done = 1'b0;
    tick();

    // first frame; FIFO full keeps the request back
    fifo_full = 1'b1;
    vsync_fall(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_req_full", slave_req, 0);
    end
    fifo_full = 1'b0;
    fifo_level = 9'd250;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("no_req_thresh", slave_req, 0);
    end
    fifo_level = 9'd249;
    tick();
    check("req_below_thresh", slave_req, 1);
    fifo_level = 9'd0;

    for (int k = 0; k < FRAME / BURST; k++) begin
      do_burst(base_m + k * BURST, 5, 1'b0);
      check("f1_active", frame_active, (k == FRAME / BURST - 1) ? 0 : 1);
    end
    // frame complete: no 5th request; stray beats and grants are harmless
    slave_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      rd_burst_data_valid = 1'b1;
      rd_burst_data = d;
      #1;
      check("done_fifo_data", w_fifo_data, d);
      tick();
      check("no_5th_req", slave_req, 0);
    end
    slave_valid = 1'b0;
    rd_burst_data_valid = 1'b0;
    check("done_active", frame_active, 0);

    // second frame: bank/channel change mid-frame is deferred
    vsync_fall(1'b1, 1'b0);
    do_burst(base_m, $urandom_range(6), 1'b0);
    sel_rd_bank = 2'd2;
    sel_rd_load = 1'b1;
    tick();
    sel_rd_load = 1'b0;
    bank_m = 2;
    read_channel = 4'd5;
    finish_frame(1);

    vsync_fall(1'b1, 1'b0);
    exp_addr_const = {2'b10, 1'b0, 4'd5, 18'd0};
    check("bank2_ch5_raddr", slave_raddr, exp_addr_const);

    // vsync falls during the burst at offset 512: burst finishes, then underrun
    do_burst(base_m, $urandom_range(6), 1'b0);
    do_burst(base_m + BURST, $urandom_range(6), 1'b0);
    do_burst(base_m + 2 * BURST, $urandom_range(6), 1'b1);
    check("ur_burst_done_active", frame_active, 1);
    check("ur_no_early_pulse", underrun_pulse, 0);
    tick();
    frame_cnt_m = (frame_cnt_m + 1) % 65536;
    ur_m = sat_inc(ur_m);
    check("ur_pulse", underrun_pulse, 1);
    check("ur_cnt", underrun_cnt, ur_m);
    check("ur_clearn", fifo_clearn, 0);
    check("ur_restart_raddr", slave_raddr, base_m);
    check("ur_frame_cnt", frame_cnt, frame_cnt_m);
    tick();
    check("ur_pulse_end", underrun_pulse, 0);
    finish_frame(0);

    // a few frames with random bank and channel
    for (int f = 0; f < 2; f++) begin
      bank_m = $urandom_range(3);
      sel_rd_bank = 2'(bank_m);
      sel_rd_load = 1'b1;
      tick();
      sel_rd_load = 1'b0;
      read_channel = 4'($urandom_range(15));
      vsync_fall(1'b1, 1'b0);
      finish_frame(0);
    end

    // saturation of the underrun counter (preloaded near the top)
    fifo_full = 1'b1;
    vsync_fall(1'b1, 1'b0);
    force dut.underrun_cnt_q = 16'hFFFE;
    #1;
    release dut.underrun_cnt_q;
    ur_m = 32'hFFFE;
    vsync_fall(1'b1, 1'b1);
    vsync_fall(1'b1, 1'b1);
    check("ur_saturated", underrun_cnt, 16'hFFFF);

    // reset in the middle of a burst
    fifo_full = 1'b0;
    n = 0;
    while (slave_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    check("rst_test_req", slave_req, 1);
    slave_valid = 1'b1;
    tick();
    slave_valid = 1'b0;
    for (int b = 0; b < 10; b++) begin
      rd_burst_data_valid = 1'b1;
      rd_burst_data = $urandom;
      tick();
    end
    ddr_rstn = 1'b0;
    #1;
    check("mid_rst_req", slave_req, 0);
    check("mid_rst_raddr", slave_raddr, 0);
    check("mid_rst_active", frame_active, 0);
    check("mid_rst_fcnt", frame_cnt, 0);
    check("mid_rst_ucnt", underrun_cnt, 0);
    check("mid_rst_clearn", fifo_clearn, 1);
    for (int b = 0; b < 5; b++) begin
      d = $urandom;
      rd_burst_data = d;
      #1;
      check("rst_fifo_en", w_fifo_en, 1);
      check("rst_fifo_data", w_fifo_data, d);
      tick();
    end
    rd_burst_data_valid = 1'b0;
    ddr_rstn = 1'b1;
    frame_cnt_m = 0;
    ur_m = 0;
    bank_m = 0;
    repeat (2) tick();
    vsync_fall(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_req", slave_req, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ddr_rdisplay_slave_mc.md
Name: ddr_rdisplay_slave_mc

Overview:
Multi-channel, parametrised DDR read master for the display path. It sits between the DDR arbiter port and the display-side async FIFO. It issues fixed-length burst read requests to refill the FIFO and walks one frame per display vsync. Bank and camera channel are latched only at frame boundaries so they never switch mid-frame. Bursts are tracked by counting returned beats rather than grant edges, and display underruns are detected and counted.

Parameters:
DATA_W, 32, read data / FIFO write width
ADDR_W, 25, slave_raddr width
OFF_W, 18, in-frame offset field width, slave_raddr[OFF_W-1:0]
CH_W, 4, channel field width, slave_raddr[OFF_W+CH_W-1:OFF_W]
BANK_W, 2, bank field width, slave_raddr[ADDR_W-1 -: BANK_W]; remaining middle bits are 0
BURST_LEN, 256, beats per burst; address advance per burst
LEN_W, 10, rd_len width
FRAME_WORDS, 245760, frame size in address units; must be a multiple of BURST_LEN and < 2^OFF_W
LVL_W, 9, fifo_level width
FIFO_THRESH, 250, request only while fifo_level < FIFO_THRESH

Ports:
ddr_clk  in  1  clock
ddr_rstn  in  1  async active-low reset
rd_burst_data_valid  in  1  DDR read beat valid
rd_burst_data  in  DATA_W  DDR read beat data
w_fifo_clk  out  1  = ddr_clk
w_fifo_en  out  1  = rd_burst_data_valid (combinational)
w_fifo_data  out  DATA_W  = rd_burst_data (combinational)
slave_req  out  1  burst request to arbiter
slave_valid  in  1  arbiter grant; command accepted
slave_raddr  out  ADDR_W  burst start address
rd_len  out  LEN_W  constant BURST_LEN
fifo_level  in  LVL_W  FIFO write-side fill level
fifo_full  in  1  FIFO full
fifo_clearn  out  1  active-low FIFO clear, 1-cycle pulse
sel_rd_load  in  1  strobe: capture sel_rd_bank
sel_rd_bank  in  BANK_W  bank written most recently by the writer
read_channel  in  CH_W  requested camera channel
vga_vs  in  1  display vsync, async to ddr_clk
frame_wr_done  in  1  pulse: first full frame written
frame_active  out  1  high while a frame is being fetched
underrun_pulse  out  1  1-cycle: vsync arrived before frame fully fetched
underrun_cnt  out  16  saturating underrun count
frame_cnt  out  16  wrapping count of frame starts

Behaviour:
- Reset values: slave_req 0, slave_raddr 0, fifo_clearn 1, frame_active 0, underrun_pulse 0, both counters 0. Internal state: FSM=WAIT_WR, bank reg 0, sticky wr_done 0.
- vga_vs passes through a 2-FF synchroniser plus 1 delay FF. vs_fall = d1 & ~d0 after sync, so it lands 3 cycles after the pin edge. vs_fall sets sticky vs_pend.
- sel_rd_load captures sel_rd_bank into the bank reg in any state.
- frame_wr_done sets the sticky wr_done, which is cleared only by reset.
- FSM:
  - WAIT_WR: when wr_done=1 -> WAIT_VS. Any vs_pend is cleared on exit.
  - WAIT_VS / DONE: on vs_pend, do a frame start, clear vs_pend, go to FILL.
  - Frame start: slave_raddr <= {bank reg, 0s, read_channel, offset 0}; fifo_clearn=0 for exactly that cycle; frame_active=1; frame_cnt+1.
  - FILL:
    - If vs_pend: underrun_pulse=1, underrun_cnt+1 (saturating at 16'hFFFF), then frame start as above.
    - Else if !fifo_full && fifo_level < FIFO_THRESH: slave_req<=1 next cycle, go to REQ.
  - REQ: slave_req held high until slave_valid=1. In the slave_valid cycle: slave_req<=0, beat counter cleared, go to BURST. slave_raddr is stable from req assertion through grant.
  - BURST: count rd_burst_data_valid beats. After beat BURST_LEN:
    - offset += BURST_LEN.
    - If new offset == FRAME_WORDS: frame_active<=0, go to DONE.
    - Else go to FILL.
  - vs_pend is never serviced in REQ or BURST; an accepted or requested command is always completed.
- Beats outside BURST are still forwarded to the FIFO but are not counted.
- slave_valid outside REQ is ignored.
- The FSM never requests while fifo_full=1, regardless of level.
- The offset never exceeds FRAME_WORDS. There is no wrap inside a frame; wrap to 0 happens only at frame start.
- read_channel and bank changes mid-frame take effect at the next frame start only.
- Reset asserted mid-burst aborts immediately to reset values. Beats still arriving afterwards pass through to the FIFO uncounted.

Test Plan:
- Bench uses FRAME_WORDS=1024, BURST_LEN=256.
- Reset, vsync edges without frame_wr_done -> slave_req stays 0, frame_cnt=0.
- frame_wr_done pulse, then vsync fall -> fifo_clearn low exactly 1 cycle, 3 cycles after the pin edge; frame_cnt=1; slave_raddr=0.
- fifo_level=0, grant after 5 cycles, 256 beats per burst -> slave_raddr steps 0, 256, 512, 768; frame_active falls after beat 1024; no 5th request.
- fifo_level=250 -> no request; drop to 249 -> slave_req next cycle. fifo_full=1 with level 0 -> no request.
- Mid-frame: sel_rd_load with bank=2 and read_channel=5 -> address unchanged until the next vsync, then slave_raddr=={2'b10,1'b0,4'd5,18'd0}.
- vsync fall during BURST at offset 512 -> burst completes, then underrun_pulse=1, underrun_cnt=1, restart at offset 0. 65536 underruns -> underrun_cnt holds 16'hFFFF.
